dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 16384, words per byte bank; bank address width AW = $clog2(DEPTH).
REQ-002 Parameter BASE, default 32'h0000_0000, byte address of bank word 0.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU access request.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, LSB-justified.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned, out-of-range or illegal funct3 access.
REQ-015 bank_addr  output  4*AW  per-bank word address, bank k at [k*AW +: AW].
REQ-016 bank_re / bank_we  output  4 each  per-bank read/write enable.
REQ-017 bank_wdata  output  32  bank k byte at [8k +: 8].
REQ-018 bank_rdata  input  32  bank k registered read byte, valid one cycle after bank_re[k].

Function
REQ-019 Byte address A = req_addr - BASE; word W = A[AW+1:2], offset O = A[1:0]; byte k of memory word W resides in bank k (little-endian).
REQ-020 req_ready = !rsp_valid || rsp_ready (combinational); at most one access outstanding.
REQ-021 Error if: H/HU with O[0]=1; W with O!=0; funct3 in {011,110,111}; any bit of A above AW+1 set (incl. req_addr < BASE).
REQ-022 Errored access drives no bank enables; rsp_err=1, rsp_rdata=0.
REQ-023 Store SB: bank_we[O]=1 with req_wdata[7:0]; SH: banks O,O+1 with [15:0]; SW: all four; all bank_addr = W.
REQ-024 Load: bank_re asserted for the same byte lanes as the equivalent store; other lanes 0.
REQ-025 Bank enables asserted only in the cycle of request acceptance; bank_addr/bank_wdata don't-care otherwise.
REQ-026 On acceptance, register: rsp_valid<=1, op kind, funct3, O, err flag.
REQ-027 Latency: response one cycle after acceptance, for loads, stores and errors alike.
REQ-028 Load data formed combinationally from bank_rdata and registered funct3/O: B sign-extends byte O; BU zero-extends; H/HU use bytes O+1:O; W returns bytes 3..0.
REQ-029 While rsp_valid && !rsp_ready: rsp_* held stable, no bank_re (bank outputs hold), req_ready=0.
REQ-030 rsp_valid && rsp_ready with new req_valid: new access accepted same cycle (back-to-back, full throughput).
REQ-031 rsp_valid && rsp_ready without new request: rsp_valid<=0 next cycle.
REQ-032 Store response: rsp_valid pulse, rsp_rdata=0, rsp_err=0.

Reset
REQ-033 Asynchronous assertion: rsp_valid=0, rsp_err=0, registered funct3/O/op=0; bank_re=bank_we=0 while rst_n low.
REQ-034 Reset mid-access discards the outstanding response; no response is ever produced for it.
REQ-035 req_ready=1 on the first cycle after deassertion.

Structure
REQ-036 Shared package dmem_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and access-kind enum.
REQ-037 Natural sub-module: dmem_load_align (combinational extract/extend from 32-bit lanes, funct3, offset).
REQ-038 Top-level instantiates no memory; four byte banks connect externally.

Verification
REQ-039 SW 0x1000 data 0xDEADBEEF, then LW 0x1000 -> bank_we=1111, rsp_rdata=0xDEADBEEF one cycle after load accept.
REQ-040 SB 0x1003 data 0x80; LB 0x1003 -> 0xFFFFFF80; LBU 0x1003 -> 0x00000080; other three bytes unchanged.
REQ-041 SH 0x1002 data 0x1234; LH 0x1002 -> 0x00001234; LHU 0x1001 -> rsp_err=1, rsp_rdata=0, no bank_re.
REQ-042 LW 0x0001_0000 (DEPTH=16384) -> rsp_err=1, bank enables 0; funct3=011 -> rsp_err=1.
REQ-043 Hold rsp_ready=0 three cycles after LW -> rsp_rdata stable, req_ready=0, no bank access; release -> next request accepted same cycle.
REQ-044 rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; no response after reset release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-banked data memory controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ACC_LOAD  = 1'b0,
    ACC_STORE = 1'b1
  } acc_kind_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B, F3_BU: m = 4'(4'b0001 << off);
      F3_H, F3_HU: m = 4'(4'b0011 << off);
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts and sign/zero-extends the addressed byte/half/word from four byte lanes.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] lanes_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = lanes_i >> {off_i, 3'b000};
    data_o  = 32'h0;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      F3_W:    data_o = lanes_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding CPU data-memory controller driving four external byte banks.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 16384,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [4*AW-1:0] bank_addr,
  output logic [3:0]    bank_re,
  output logic [3:0]    bank_we,
  output logic [31:0]   bank_wdata,
  input  logic [31:0]   bank_rdata
);

  localparam logic [31:0] HI_MASK = ~((32'd1 << (AW + 2)) - 32'd1);

  logic [31:0] byte_a;
  logic [1:0]  off;
  logic [AW-1:0] word;
  logic        range_err, align_err, req_err, accept;
  logic [3:0]  lanes;
  logic [31:0] aligned;

  logic        rsp_valid_q, rsp_valid_d;
  acc_kind_e   kind_q, kind_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;

  // Request decode; errors and reset suppress every bank enable.
  always_comb begin
    byte_a    = req_addr - BASE;
    off       = byte_a[1:0];
    word      = byte_a[AW+1:2];
    range_err = |(byte_a & HI_MASK);
    align_err = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && off[0]) ||
                ((req_funct3 == F3_W) && (off != 2'b00));
    req_err   = range_err || align_err || f3_illegal(req_funct3);
    req_ready = !rsp_valid_q || rsp_ready;
    accept    = req_valid && req_ready;
    lanes     = (accept && !req_err && rst_n) ? lane_mask(req_funct3, off) : 4'b0000;
    bank_we   = req_we ? lanes : 4'b0000;
    bank_re   = req_we ? 4'b0000 : lanes;
    bank_addr = {4{word}};
    case (req_funct3[1:0])
      2'b00:   bank_wdata = {4{req_wdata[7:0]}};
      2'b01:   bank_wdata = {2{req_wdata[15:0]}};
      default: bank_wdata = req_wdata;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    kind_d      = kind_q;
    f3_d        = f3_q;
    off_d       = off_q;
    err_d       = err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      kind_d      = req_we ? ACC_STORE : ACC_LOAD;
      f3_d        = req_funct3;
      off_d       = off;
      err_d       = req_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      kind_q      <= ACC_LOAD;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      kind_q      <= kind_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      err_q       <= err_d;
    end
  end

  dmem_load_align u_align (
    .lanes_i  (bank_rdata),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (aligned)
  );

  // Banks hold their read data while stalled, so the load result stays stable.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && err_q;
  assign rsp_rdata = (rsp_valid_q && (kind_q == ACC_LOAD) && !err_q) ? aligned : 32'h0;

endmodule
